oc8051_wbd_responder: RTL and testbench
=======================================

# oc8051_wbd_responder

Wishbone classic responder for the oc8051 external data bus: the slave end of the core's `wbd_*` master port. It serves 8-bit reads and writes from a local byte RAM and inserts programmable wait states. Out-of-range accesses are answered with an error. It sits beside `oc8051_fv_top` in simulation and FV harnesses, replacing free-running stimulus on `wbd_dat_i`/`wbd_ack_i`/`wbd_err_i` with protocol-correct responses.

## Interface
Parameters:
- `ADDR_W`, default 16: width of the core's data address.
- `MEM_DEPTH`, default 256: number of bytes in the local RAM (power of two, ≤ 2^ADDR_W).
- `CNT_W`, default 16: width of the transfer counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `wbd_cyc_i`, in, 1: bus cycle active.
- `wbd_stb_i`, in, 1: strobe; a request is present.
- `wbd_we_i`, in, 1: 1 = write, 0 = read.
- `wbd_adr_i`, in, ADDR_W: byte address.
- `wbd_dat_i`, in, 8: write data from the core.
- `wait_i`, in, 4: number of wait states for the next accepted request.
- `wbd_dat_o`, out, 8: read data, valid only while `wbd_ack_o` is high.
- `wbd_ack_o`, out, 1: one-cycle acknowledge.
- `wbd_err_o`, out, 1: one-cycle error; never high together with ack.
- `xfer_cnt_o`, out, CNT_W: count of completed transfers (ack or err).
- `busy_o`, out, 1: high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE → WAIT when `cyc&stb` and `wait_i`≠0.
  - IDLE → RESP when `cyc&stb` and `wait_i`=0.
  - WAIT → RESP when the down-counter reaches 0.
  - RESP → IDLE unconditionally.
- On accept, the block latches `adr`, `we`, `dat` and the wait count. Bus inputs are ignored until the next return to IDLE.
- WAIT decrements the latched count by 1 per cycle. In RESP, exactly one of `wbd_ack_o`/`wbd_err_o` is high for one cycle.
- Address decode: latched `adr` < MEM_DEPTH → ack, else err.
- Write with ack: RAM[adr] ← latched data on the RESP clock edge.
- Read with ack: `wbd_dat_o` = RAM[adr] during RESP. `wbd_dat_o` is 0x00 in all other cycles, including error responses.
- Error response: no RAM write occurs.
- Abort: if `wbd_cyc_i` is low in any WAIT cycle, go to IDLE next edge with no response, no write and no count.
- A response is still issued in RESP even if `cyc` drops that cycle. Its write commits, and it is counted.
- `xfer_cnt_o` increments by 1 on each RESP cycle and wraps modulo 2^CNT_W.
- Reset:
  - FSM goes to IDLE; `wbd_ack_o`=0, `wbd_err_o`=0, `wbd_dat_o`=0x00, `xfer_cnt_o`=0, `busy_o`=0.
  - RAM contents are not reset.
  - Reset asserted mid-transfer drops the transfer with no response and no write.

## Timing
- Latency: request sampled on edge N → ack/err high during cycle N+1+W, where W is the latched `wait_i`.
- W=0 gives ack in the cycle after the request is sampled.
- After RESP the block spends one cycle in IDLE. Back-to-back requests are therefore accepted at most every W+2 cycles.
- The core must hold `stb` high until ack/err. A `stb` still high in the IDLE cycle after RESP is treated as a new request.
- Read data is registered, never combinational from `wbd_adr_i`.
- Simultaneous reset and request: reset wins.
- `wait_i` changes during WAIT have no effect.

## Structure
- Shared package `oc8051_wb_pkg`:
  - state enum `{IDLE, WAIT, RESP}`;
  - `WAIT_W`=4;
  - default data `8'h00`.
- Sub-module `oc8051_wbd_ram`: single-port, synchronous-write, asynchronous-read byte RAM of MEM_DEPTH entries. The responder registers its output.
- Target 150–250 lines total.

## Test plan
- Reset with `rst_n`=0 mid-WAIT → all outputs 0 in the same cycle. No ack follows, and RAM[0x10] is unchanged.
- Write 0xA5 to 0x0010 with `wait_i`=0, then read 0x0010 → ack one cycle after each request. Read returns `wbd_dat_o`=0xA5; `xfer_cnt_o`=2.
- Read with `wait_i`=3 → ack exactly 4 cycles after the request is sampled, high for one cycle only; `busy_o` high for 4 cycles.
- Write 0x5A to 0x0100 with MEM_DEPTH=256 → `wbd_err_o` pulses and ack stays 0. A read of 0x0000 shows the RAM is unaltered; `wbd_dat_o`=0x00 during the error.
- Abort: request with `wait_i`=5, drop `cyc` after 2 cycles → no ack/err, no write, `xfer_cnt_o` unchanged, IDLE next cycle.
- Counter wrap with CNT_W=4: 17 transfers → `xfer_cnt_o`=1. Back-to-back requests with W=0 are accepted every 2 cycles.

Source files
------------

// File: rtl/oc8051_wb_pkg.sv
// Shared types and constants for the oc8051 Wishbone data-bus responder.
package oc8051_wb_pkg;

    localparam int         WAIT_W      = 4;
    localparam logic [7:0] DAT_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/oc8051_wbd_if.sv
// Wishbone classic data-bus bundle between the oc8051 core (master) and a responder (slave).
interface oc8051_wbd_if #(
    parameter int ADDR_W = 16
) ();

    logic              wbd_cyc_i;
    logic              wbd_stb_i;
    logic              wbd_we_i;
    logic [ADDR_W-1:0] wbd_adr_i;
    logic [7:0]        wbd_dat_i;
    logic [7:0]        wbd_dat_o;
    logic              wbd_ack_o;
    logic              wbd_err_o;

    modport slave (
        input  wbd_cyc_i, wbd_stb_i, wbd_we_i, wbd_adr_i, wbd_dat_i,
        output wbd_dat_o, wbd_ack_o, wbd_err_o
    );

    modport master (
        output wbd_cyc_i, wbd_stb_i, wbd_we_i, wbd_adr_i, wbd_dat_i,
        input  wbd_dat_o, wbd_ack_o, wbd_err_o
    );

endinterface

// File: rtl/oc8051_wbd_ram.sv
// Single-port byte RAM: synchronous write, asynchronous read. Contents are never reset.
module oc8051_wbd_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [7:0]    wdat,
    output logic [7:0]    rdat
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[adr] <= wdat;
    end

    assign rdat = mem[adr];

endmodule

// File: rtl/oc8051_wbd_responder.sv
// Wishbone classic slave for the oc8051 wbd_* port: local byte RAM, programmable
// wait states, error on out-of-range addresses. All bus outputs are registered.
module oc8051_wbd_responder
    import oc8051_wb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 256,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    oc8051_wbd_if.slave       wbd,
    input  logic [WAIT_W-1:0] wait_i,
    output logic [CNT_W-1:0]  xfer_cnt_o,
    output logic              busy_o
);

    localparam int              AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    state_e            state, state_n;
    logic [ADDR_W-1:0] adr_q;
    logic              we_q;
    logic [7:0]        dat_q;
    logic [WAIT_W-1:0] cnt_q;
    logic              ack_q, err_q;
    logic [7:0]        rdat_q;
    logic [CNT_W-1:0]  xfer_q;

    logic              req, accept, enter_resp;
    logic [ADDR_W-1:0] cur_adr;
    logic              cur_we, cur_hit;
    logic              ram_we;
    logic [7:0]        ram_rdat;

    assign req    = wbd.wbd_cyc_i & wbd.wbd_stb_i;
    assign accept = (state == IDLE) & req;

    // In IDLE the live bus is the request about to be latched; afterwards only the latched copy counts.
    assign cur_adr = (state == IDLE) ? wbd.wbd_adr_i : adr_q;
    assign cur_we  = (state == IDLE) ? wbd.wbd_we_i  : we_q;
    assign cur_hit = ({1'b0, cur_adr} < DEPTH_L);
    assign ram_we  = (state == RESP) & cur_we & cur_hit;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (req) state_n = (wait_i != '0) ? WAIT : RESP;
            WAIT: begin
                if (!wbd.wbd_cyc_i)          state_n = IDLE;
                else if (cnt_q <= WAIT_W'(1)) state_n = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign enter_resp = (state_n == RESP) & (state != RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q <= '0;
            we_q  <= 1'b0;
            dat_q <= DAT_DEFAULT;
            cnt_q <= '0;
        end else if (accept) begin
            adr_q <= wbd.wbd_adr_i;
            we_q  <= wbd.wbd_we_i;
            dat_q <= wbd.wbd_dat_i;
            cnt_q <= wait_i;
        end else if (state == WAIT) begin
            cnt_q <= cnt_q - WAIT_W'(1);
        end
    end

    // Response registers are loaded on the edge that enters RESP, so they are valid for exactly that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= DAT_DEFAULT;
            xfer_q <= '0;
        end else begin
            ack_q  <= enter_resp & cur_hit;
            err_q  <= enter_resp & ~cur_hit;
            rdat_q <= (enter_resp & cur_hit & ~cur_we) ? ram_rdat : DAT_DEFAULT;
            if (state == RESP) xfer_q <= xfer_q + CNT_W'(1);
        end
    end

    oc8051_wbd_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .adr  (cur_adr[AW-1:0]),
        .wdat (dat_q),
        .rdat (ram_rdat)
    );

    assign wbd.wbd_ack_o = ack_q;
    assign wbd.wbd_err_o = err_q;
    assign wbd.wbd_dat_o = rdat_q;
    assign xfer_cnt_o    = xfer_q;
    assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_oc8051_wbd_responder.sv
// Directed bench for oc8051_wbd_responder (MEM_DEPTH=256, CNT_W=4).
module tb_oc8051_wbd_responder;

    logic       clk;
    logic       rst_n;
    logic [3:0] wait_i;
    logic [3:0] xfer_cnt;
    logic       busy;
    int         n_assert;
    int         n_fail;

    oc8051_wbd_if #(.ADDR_W(16)) bus ();

    oc8051_wbd_responder #(
        .ADDR_W    (16),
        .MEM_DEPTH (256),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wbd        (bus),
        .wait_i     (wait_i),
        .xfer_cnt_o (xfer_cnt),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [15:0] adr, input logic [7:0] dat, input logic [3:0] w);
        bus.wbd_cyc_i = 1'b1;
        bus.wbd_stb_i = 1'b1;
        bus.wbd_we_i  = we;
        bus.wbd_adr_i = adr;
        bus.wbd_dat_i = dat;
        wait_i        = w;
    endtask

    task automatic idle_bus();
        bus.wbd_cyc_i = 1'b0;
        bus.wbd_stb_i = 1'b0;
        bus.wbd_we_i  = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.wbd_adr_i = '0;
        bus.wbd_dat_i = '0;
        wait_i   = '0;
        idle_bus();
        tick();
        tick();
        chk("rst_ack", 32'(bus.wbd_ack_o), 0);
        chk("rst_err", 32'(bus.wbd_err_o), 0);
        chk("rst_dat", 32'(bus.wbd_dat_o), 0);
        chk("rst_cnt", 32'(xfer_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        // write A5 -> 0x10, W=0
        req(1'b1, 16'h0010, 8'hA5, 4'd0);
        tick();
        chk("wr_ack", 32'(bus.wbd_ack_o), 1);
        chk("wr_err", 32'(bus.wbd_err_o), 0);
        chk("wr_dat", 32'(bus.wbd_dat_o), 0);
        chk("wr_busy", 32'(busy), 1);
        idle_bus();
        tick();
        chk("wr_ack_end", 32'(bus.wbd_ack_o), 0);
        chk("wr_cnt", 32'(xfer_cnt), 1);
        chk("wr_busy_end", 32'(busy), 0);

        // read 0x10, W=0
        req(1'b0, 16'h0010, 8'h00, 4'd0);
        tick();
        chk("rd_ack", 32'(bus.wbd_ack_o), 1);
        chk("rd_dat", 32'(bus.wbd_dat_o), 32'hA5);
        idle_bus();
        tick();
        chk("rd_ack_end", 32'(bus.wbd_ack_o), 0);
        chk("rd_dat_end", 32'(bus.wbd_dat_o), 0);
        chk("rd_cnt", 32'(xfer_cnt), 2);

        // read 0x10, W=3; wait_i change during WAIT must not matter
        req(1'b0, 16'h0010, 8'h00, 4'd3);
        tick();
        chk("w3_ack0", 32'(bus.wbd_ack_o), 0);
        chk("w3_busy0", 32'(busy), 1);
        wait_i = 4'd0;
        tick();
        chk("w3_ack1", 32'(bus.wbd_ack_o), 0);
        chk("w3_busy1", 32'(busy), 1);
        tick();
        chk("w3_ack2", 32'(bus.wbd_ack_o), 0);
        chk("w3_busy2", 32'(busy), 1);
        tick();
        chk("w3_ack3", 32'(bus.wbd_ack_o), 1);
        chk("w3_dat3", 32'(bus.wbd_dat_o), 32'hA5);
        chk("w3_busy3", 32'(busy), 1);
        idle_bus();
        tick();
        chk("w3_ack_end", 32'(bus.wbd_ack_o), 0);
        chk("w3_busy_end", 32'(busy), 0);
        chk("w3_cnt", 32'(xfer_cnt), 3);

        // seed 0x0000 with 3C, then out-of-range write to 0x0100 (aliases 0x00 in low bits)
        req(1'b1, 16'h0000, 8'h3C, 4'd0);
        tick();
        idle_bus();
        tick();
        req(1'b1, 16'h0100, 8'h5A, 4'd0);
        tick();
        chk("oor_err", 32'(bus.wbd_err_o), 1);
        chk("oor_ack", 32'(bus.wbd_ack_o), 0);
        chk("oor_dat", 32'(bus.wbd_dat_o), 0);
        idle_bus();
        tick();
        chk("oor_err_end", 32'(bus.wbd_err_o), 0);
        chk("oor_cnt", 32'(xfer_cnt), 5);
        req(1'b0, 16'h0000, 8'h00, 4'd0);
        tick();
        chk("oor_rd_ack", 32'(bus.wbd_ack_o), 1);
        chk("oor_rd_dat", 32'(bus.wbd_dat_o), 32'h3C);
        idle_bus();
        tick();
        chk("oor_rd_cnt", 32'(xfer_cnt), 6);

        // abort: write 77 -> 0x0000 with W=5, drop cyc after 2 WAIT cycles
        req(1'b1, 16'h0000, 8'h77, 4'd5);
        tick();
        chk("ab_busy0", 32'(busy), 1);
        tick();
        chk("ab_busy1", 32'(busy), 1);
        idle_bus();
        tick();
        chk("ab_idle", 32'(busy), 0);
        for (int i = 0; i < 6; i++) begin
            chk("ab_noack", 32'(bus.wbd_ack_o), 0);
            chk("ab_noerr", 32'(bus.wbd_err_o), 0);
            tick();
        end
        chk("ab_cnt", 32'(xfer_cnt), 6);
        req(1'b0, 16'h0000, 8'h00, 4'd0);
        tick();
        chk("ab_rd_dat", 32'(bus.wbd_dat_o), 32'h3C);
        idle_bus();
        tick();
        chk("ab_rd_cnt", 32'(xfer_cnt), 7);

        // reset mid-WAIT: write FF -> 0x10, W=4
        req(1'b1, 16'h0010, 8'hFF, 4'd4);
        tick();
        tick();
        chk("mr_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_ack", 32'(bus.wbd_ack_o), 0);
        chk("mr_err", 32'(bus.wbd_err_o), 0);
        chk("mr_dat", 32'(bus.wbd_dat_o), 0);
        chk("mr_cnt", 32'(xfer_cnt), 0);
        chk("mr_busy", 32'(busy), 0);
        tick();
        chk("mr_ack_hold", 32'(bus.wbd_ack_o), 0);
        idle_bus();
        rst_n = 1'b1;
        tick();
        chk("mr_ack_post", 32'(bus.wbd_ack_o), 0);
        chk("mr_busy_post", 32'(busy), 0);

        // back-to-back reads of 0x10 with stb held: one accept every 2 cycles, counter wraps at 16
        req(1'b0, 16'h0010, 8'h00, 4'd0);
        for (int i = 0; i < 17; i++) begin
            tick();
            chk("bb_ack", 32'(bus.wbd_ack_o), 1);
            chk("bb_dat", 32'(bus.wbd_dat_o), 32'hA5);
            if (i == 16) idle_bus();
            tick();
            chk("bb_gap", 32'(bus.wbd_ack_o), 0);
            chk("bb_cnt", 32'(xfer_cnt), 32'((i + 1) % 16));
        end
        chk("wrap_cnt", 32'(xfer_cnt), 1);
        chk("wrap_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
